// File: rtl/cv32e40p_obi_mem_pkg.sv
// Shared types and limits for the OBI memory responder.
// Response entries pair returned read data with a grant-relative age.
package cv32e40p_obi_mem_pkg;

  localparam int unsigned MAX_RESP_LAT = 15;
  localparam int unsigned MAX_WAIT     = 15;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  age;
  } resp_entry_t;

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO with per-entry aging toward RESP_LAT.
// Ports: push/rdata in, pop in, head valid/rdata out, full, count.
module cv32e40p_obi_resp_fifo
  import cv32e40p_obi_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESP_LAT = 1,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [31:0]   push_rdata_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output logic [31:0]   head_rdata_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    LAT     = 4'(RESP_LAT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  resp_entry_t   r_buf [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  resp_entry_t   w_head;

  assign w_head       = r_buf[r_rptr];
  assign head_valid_o = (r_count != '0) && (w_head.age == LAT);
  assign head_rdata_o = w_head.rdata;
  assign full_o       = (r_count == DEPTH_C);
  assign count_o      = r_count;

  // A new entry already ages during its grant cycle, so it is
  // stored with age 1; head becomes eligible RESP_LAT cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (r_wptr == PW'(i))) begin
          r_buf[i].rdata <= push_rdata_i;
          r_buf[i].age   <= 4'd1;
        end else if (r_buf[i].age < LAT) begin
          r_buf[i].age <= r_buf[i].age + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) begin
        r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
      end
      if (pop_i) begin
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI data-side memory responder: SRAM, grant stall, in-order responses.
// Ports: clk/rst, OBI req/gnt/rvalid/we/be/addr/wdata/rdata, stalls, count.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_mem_pkg::*;
#(
  parameter int unsigned MEM_AW          = 12,
  parameter int unsigned RESP_LAT        = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic [3:0]  gnt_stall_i,
  input  logic        resp_stall_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [3:0]        r_wait;
  logic [31:0]       r_mem [DEPTH];

  logic [MEM_AW-1:0] w_idx;
  logic              w_gnt;
  logic              w_full;
  logic              w_pop;
  logic              w_head_valid;
  logic [31:0]       w_head_rdata;
  logic [31:0]       w_push_rdata;
  logic [CW-1:0]     w_count;
  logic              w_unused_addr;

  assign w_idx         = data_addr_i[MEM_AW+1:2];
  assign w_unused_addr = ^{data_addr_i[31:MEM_AW+2], data_addr_i[1:0]};

  // Full is derived from the registered count, so a pop in the same
  // cycle never frees a slot for this cycle's grant.
  assign w_gnt      = data_req_i && (r_wait >= gnt_stall_i) && !w_full;
  assign data_gnt_o = w_gnt;

  assign w_push_rdata = data_we_i ? 32'h0 : r_mem[w_idx];

  assign w_pop         = w_head_valid && !resp_stall_i;
  assign data_rvalid_o = w_pop;
  assign data_rdata_o  = w_pop ? w_head_rdata : 32'h0;
  assign outstanding_o = w_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait <= '0;
    end else if (!data_req_i || w_gnt) begin
      r_wait <= '0;
    end else if (r_wait != 4'(MAX_WAIT)) begin
      r_wait <= r_wait + 4'd1;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_gnt && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  cv32e40p_obi_resp_fifo #(
    .DEPTH    (MAX_OUTSTANDING),
    .RESP_LAT (RESP_LAT),
    .CW       (CW)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (w_gnt),
    .push_rdata_i (w_push_rdata),
    .pop_i        (w_pop),
    .head_valid_o (w_head_valid),
    .head_rdata_o (w_head_rdata),
    .full_o       (w_full),
    .count_o      (w_count)
  );

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Directed self-checking bench for the OBI memory responder.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_cv32e40p_obi_mem_responder;

  logic        clk;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic [3:0]  gnt_stall_i;
  logic        resp_stall_i;
  logic [1:0]  outstanding_o;

  int checks   = 0;
  int failures = 0;

  cv32e40p_obi_mem_responder #(
    .MEM_AW          (12),
    .RESP_LAT        (1),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .gnt_stall_i   (gnt_stall_i),
    .resp_stall_i  (resp_stall_i),
    .outstanding_o (outstanding_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic req, input logic we,
                       input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    data_req_i   = req;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    gnt_stall_i  = 4'd0;
    resp_stall_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (data_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_gnt got=%0b exp=0", data_gnt_o);
    end
    checks++;
    if (data_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_rvalid got=%0b exp=0", data_rvalid_o);
    end
    checks++;
    if (data_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_rdata got=%h exp=0", data_rdata_o);
    end
    checks++;
    if (outstanding_o !== 2'd0) begin
      failures++;
      $display("FAIL rst_outstanding got=%0d exp=0", outstanding_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_write_read;
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL wr_gnt got=%0b exp=1", data_gnt_o);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL rd_gnt got=%0b exp=1", data_gnt_o);
    end
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL wr_resp got=%0b/%h exp=1/0", data_rvalid_o, data_rdata_o);
    end
    checks++;
    if (outstanding_o !== 2'd1) begin
      failures++;
      $display("FAIL wr_outst got=%0d exp=1", outstanding_o);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_resp got=%0b/%h exp=1/deadbeef",
               data_rvalid_o, data_rdata_o);
    end
    @(negedge clk); #1;
    checks++;
    if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h0 ||
        outstanding_o !== 2'd0) begin
      failures++;
      $display("FAIL rd_idle got=%0b/%h/%0d exp=0/0/0",
               data_rvalid_o, data_rdata_o, outstanding_o);
    end
  endtask

  task automatic test_byte_lanes;
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hF, 32'h40, 32'h11223344); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL be_pre_gnt got=%0b exp=1", data_gnt_o);
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 4'b0101, 32'h40, 32'hAABBCCDD);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 32'h40, 32'h0); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL be_rd_gnt got=%0b exp=1", data_gnt_o);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h11BB33DD) begin
      failures++;
      $display("FAIL be_merge got=%0b/%h exp=1/11bb33dd",
               data_rvalid_o, data_rdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_grant_stall;
    logic exp_g;
    logic exp_v;
    @(negedge clk);
    gnt_stall_i = 4'd3;
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 8) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      exp_g = (i == 3) || (i == 7);
      exp_v = (i == 4) || (i == 8);
      checks++;
      if (data_gnt_o !== exp_g) begin
        failures++;
        $display("FAIL stall_gnt c%0d got=%0b exp=%0b", i, data_gnt_o, exp_g);
      end
      checks++;
      if (data_rvalid_o !== exp_v ||
          data_rdata_o !== (exp_v ? 32'hDEADBEEF : 32'h0)) begin
        failures++;
        $display("FAIL stall_resp c%0d got=%0b/%h exp=%0b",
                 i, data_rvalid_o, data_rdata_o, exp_v);
      end
    end
    gnt_stall_i = 4'd0;
  endtask

  task automatic test_full_backpressure;
    @(negedge clk);
    resp_stall_i = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 32'h40, 32'h0); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL full_a_gnt got=%0b exp=1", data_gnt_o);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0); #1;
    checks++;
    if (data_gnt_o !== 1'b1 || data_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL full_b got=%0b/%0b exp=1/0", data_gnt_o, data_rvalid_o);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (data_gnt_o !== 1'b0 || outstanding_o !== 2'd2 ||
          data_rvalid_o !== 1'b0) begin
        failures++;
        $display("FAIL full_hold c%0d got=%0b/%0d/%0b exp=0/2/0",
                 i, data_gnt_o, outstanding_o, data_rvalid_o);
      end
    end
    @(negedge clk);
    resp_stall_i = 1'b0; #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h11BB33DD ||
        data_gnt_o !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_a got=%0b/%h/%0b exp=1/11bb33dd/0",
               data_rvalid_o, data_rdata_o, data_gnt_o);
    end
    @(negedge clk); #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEADBEEF ||
        data_gnt_o !== 1'b1 || outstanding_o !== 2'd1) begin
      failures++;
      $display("FAIL full_pop_b got=%0b/%h/%0b/%0d exp=1/deadbeef/1/1",
               data_rvalid_o, data_rdata_o, data_gnt_o, outstanding_o);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h11BB33DD ||
        outstanding_o !== 2'd1) begin
      failures++;
      $display("FAIL full_pop_c got=%0b/%h/%0d exp=1/11bb33dd/1",
               data_rvalid_o, data_rdata_o, outstanding_o);
    end
    @(negedge clk); #1;
    checks++;
    if (data_rvalid_o !== 1'b0 || outstanding_o !== 2'd0) begin
      failures++;
      $display("FAIL full_drain got=%0b/%0d exp=0/0",
               data_rvalid_o, outstanding_o);
    end
  endtask

  task automatic test_alias;
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'h5);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h0000_4008, 32'h0); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL alias_gnt got=%0b exp=1", data_gnt_o);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h5) begin
      failures++;
      $display("FAIL alias_rd got=%0b/%h exp=1/5", data_rvalid_o, data_rdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    resp_stall_i = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++;
    if (outstanding_o !== 2'd2) begin
      failures++;
      $display("FAIL rmid_pre got=%0d exp=2", outstanding_o);
    end
    rst_ni       = 1'b0;
    resp_stall_i = 1'b0; #1;
    checks++;
    if (outstanding_o !== 2'd0 || data_rvalid_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async got=%0d/%0b exp=0/0",
               outstanding_o, data_rvalid_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (data_rvalid_o !== 1'b0 || outstanding_o !== 2'd0) begin
        failures++;
        $display("FAIL rmid_post c%0d got=%0b/%0d exp=0/0",
                 i, data_rvalid_o, outstanding_o);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h100, 32'h0); #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      failures++;
      $display("FAIL rmid_gnt got=%0b exp=1", data_gnt_o);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    checks++;
    if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rmid_mem got=%0b/%h exp=1/deadbeef",
               data_rvalid_o, data_rdata_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_grant_stall();
    test_full_backpressure();
    test_alias();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
